// File: rtl/fpu_sp_arb.sv
// fpu_sp_arb: round-robin arbiter/sequencer sharing one single-precision FPU among NREQ requesters.
// Optional macro FPU_ARB_TIMEOUT_EN adds a WAIT watchdog that answers rsp_err after TIMEOUT cycles.
module fpu_sp_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [4*NREQ-1:0]    req_cmd,
  input  logic [32*NREQ-1:0]   req_din1,
  input  logic [32*NREQ-1:0]   req_din2,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [3:0]           fpu_cmd,
  output logic [31:0]          fpu_din1,
  output logic [31:0]          fpu_din2,
  output logic                 fpu_dval,
  input  logic [31:0]          fpu_result,
  input  logic                 fpu_rdy,
  output logic [1:0]           dbg_state
);
  localparam int LW = (NREQ > 2) ? 2 : 1;

  // Command encodings understood by the FPU top.
  localparam logic [3:0] CMD_FPU_SP_ADD = 4'h1;
  localparam logic [3:0] CMD_FPU_SP_MUL = 4'h2;
  localparam logic [3:0] CMD_FPU_SP_DIV = 4'h3;
  localparam logic [3:0] CMD_FPU_SP_F2I = 4'h4;
  localparam logic [3:0] CMD_FPU_SP_I2F = 4'h5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [31:0]     din1_q, din1_d, din2_q, din2_d;
  logic            dval_q, dval_d;
  logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            found;
  logic [LW-1:0]   grant, cand;
  logic [3:0]      g_cmd;
  logic [31:0]     g_din1, g_din2;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [LW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == CMD_FPU_SP_ADD) || (c == CMD_FPU_SP_MUL) || (c == CMD_FPU_SP_DIV) ||
           (c == CMD_FPU_SP_F2I) || (c == CMD_FPU_SP_I2F);
  endfunction

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = last_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last_q) + k) % NREQ);
      if (!found && req_vld[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign g_cmd  = req_cmd[{grant, 2'b00} +: 4];
  assign g_din1 = req_din1[{grant, 5'b00000} +: 32];
  assign g_din2 = req_din2[{grant, 5'b00000} +: 32];

  always_comb begin
    req_ack = '0;
    if (state_q == S_IDLE && found) req_ack[grant] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cmd_d      = cmd_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    dval_d     = 1'b0;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          last_d = grant;
          if (cmd_valid(g_cmd)) begin
            cmd_d   = g_cmd;
            din1_d  = g_din1;
            din2_d  = g_din2;
            dval_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            // Bad command never reaches the FPU, so its inputs keep the last issued op.
            rsp_vld_d  = onehot(grant);
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (fpu_rdy) begin
          rsp_vld_d  = onehot(last_q);
          rsp_data_d = fpu_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_vld_d  = onehot(last_q);
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= LW'(NREQ - 1);
      cmd_q      <= '0;
      din1_q     <= '0;
      din2_q     <= '0;
      dval_q     <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cmd_q      <= cmd_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      dval_q     <= dval_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign fpu_cmd   = cmd_q;
  assign fpu_din1  = din1_q;
  assign fpu_din2  = din2_q;
  assign fpu_dval  = dval_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fpu_sp_arb.sv
// tb_fpu_sp_arb: directed and randomized checks of fpu_sp_arb against a transaction-level model
// and a fake FPU with programmable latency.
module tb_fpu_sp_arb;
  localparam int NREQ = 3;
  localparam int TO   = 8;
  localparam logic [3:0] ADD = 4'h1, MUL = 4'h2, DIV = 4'h3, F2I = 4'h4, I2F = 4'h5;
  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000, F4 = 32'h40800000;

  logic                 clk, rst_n;
  logic [NREQ-1:0]      req_vld, req_ack, rsp_vld;
  logic [4*NREQ-1:0]    req_cmd;
  logic [32*NREQ-1:0]   req_din1, req_din2;
  logic [31:0]          rsp_data, fpu_din1, fpu_din2, fpu_result;
  logic                 rsp_err, busy, fpu_dval, fpu_rdy;
  logic [3:0]           fpu_cmd;
  logic [1:0]           dbg_state;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  fpu_sp_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_cmd(req_cmd), .req_din1(req_din1),
    .req_din2(req_din2), .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1),
    .fpu_din2(fpu_din2), .fpu_dval(fpu_dval), .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- fake FPU ----------------
  int         fpu_lat   = 3;
  bit         fpu_never = 1'b0;
  bit         fpu_rand  = 1'b0;
  int         fpu_cnt   = 0;
  logic [3:0] f_cmd;
  logic [31:0] f_a, f_b;

  function automatic logic [31:0] fpu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == ADD && a == F1 && b == F2) return F3;
    if (c == MUL && a == F2 && b == F3) return 32'h40C00000;
    if (c == DIV && a == F1 && b == F4) return 32'h3E800000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {28'h0, c};
  endfunction

  initial begin
    fpu_rdy = 1'b0;
    fpu_result = '0;
    forever begin
      @(posedge clk); #1;
      fpu_rdy = 1'b0;
      fpu_result = $urandom();
      if (!rst_n) fpu_cnt = 0;
      else if (fpu_dval) begin
        f_cmd = fpu_cmd; f_a = fpu_din1; f_b = fpu_din2;
        if (fpu_never) fpu_cnt = 0;
        else if (fpu_rand) fpu_cnt = int'($urandom_range(1, 6));
        else fpu_cnt = fpu_lat;
      end else if (fpu_cnt > 0) begin
        fpu_cnt--;
        if (fpu_cnt == 0) begin
          fpu_rdy = 1'b1;
          fpu_result = fpu_fn(f_cmd, f_a, f_b);
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int          cyc = 0;
  bit          m_busy, m_wait;
  int          m_last, m_owner, m_issue, m_rsp;
  logic [31:0] m_data, m_fa, m_fb;
  logic        m_err;
  logic [3:0]  m_fcmd;

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_last = NREQ - 1; m_owner = 0; m_issue = -1; m_rsp = -1;
    m_data = '0; m_err = 0; m_fcmd = '0; m_fa = '0; m_fb = '0;
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] exp_ack, exp_rsp;
    logic [3:0] c;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dval", 32'(fpu_dval), 0);
        chk("rst_fpu_cmd", 32'(fpu_cmd), 0);
        chk("rst_fpu_din1", fpu_din1, 0);
        chk("rst_fpu_din2", fpu_din2, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        model_reset();
      end else begin
        exp_ack = '0;
        g = -1;
        if (!m_busy && (|req_vld)) begin
          g = rr_pick(m_last, req_vld);
          exp_ack[g] = 1'b1;
        end
        exp_rsp = '0;
        if (m_busy && cyc == m_rsp) exp_rsp[m_owner] = 1'b1;
        chk("ack", 32'(req_ack), 32'(exp_ack));
        chk("rsp_vld", 32'(rsp_vld), 32'(exp_rsp));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("dval", 32'(fpu_dval), 32'(m_wait && cyc == m_issue));
        chk("fpu_cmd", 32'(fpu_cmd), 32'(m_fcmd));
        chk("fpu_din1", fpu_din1, m_fa);
        chk("fpu_din2", fpu_din2, m_fb);
        if (exp_rsp != '0) begin
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        if (g >= 0) begin
          m_busy = 1; m_owner = g; m_last = g;
          c = req_cmd[4*g +: 4];
          if (c inside {ADD, MUL, DIV, F2I, I2F}) begin
            m_wait = 1; m_issue = cyc + 1; m_rsp = -1;
            m_fcmd = c; m_fa = req_din1[32*g +: 32]; m_fb = req_din2[32*g +: 32];
          end else begin
            m_rsp = cyc + 1; m_data = '0; m_err = 1;
          end
        end else if (m_wait && cyc > m_issue) begin
          if (fpu_rdy) begin
            m_wait = 0; m_rsp = cyc + 1; m_data = fpu_result; m_err = 0;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (cyc == m_issue + TO) begin
            m_wait = 0; m_rsp = cyc + 1; m_data = '0; m_err = 1;
          end
`endif
        end else if (m_busy && cyc == m_rsp) begin
          m_busy = 0;
        end
      end
      cyc++;
    end
  end

  // ---------------- driver ----------------
  // Caller is positioned just after a rising edge. Returns response, cycles waited for ack,
  // and cycles from ack to rsp_vld.
  task automatic do_req(input int i, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic e, output int lat, output int w);
    int n;
    bit ok;
    d = '0; e = 1'b0; lat = -1; w = -1;
    req_cmd[4*i +: 4] = cmd;
    req_din1[32*i +: 32] = a;
    req_din2[32*i +: 32] = b;
    req_vld[i] = 1'b1;
    n = 0; ok = 0;
    while (n < 500 && !ok) begin
      @(negedge clk);
      if (req_ack[i]) ok = 1; else n++;
    end
    if (!ok) begin
      mis_cnt++;
      $display("FAIL ack_timeout req=%0d got=no_ack want=ack", i);
    end
    w = n;
    @(posedge clk); #1;
    req_vld[i] = 1'b0;
    if (!ok) return;
    n = 1; ok = 0;
    while (n < 500 && !ok) begin
      @(negedge clk);
      if (rsp_vld[i]) begin
        ok = 1; d = rsp_data; e = rsp_err;
      end else n++;
    end
    if (!ok) begin
      mis_cnt++;
      $display("FAIL rsp_timeout req=%0d got=no_rsp want=rsp", i);
    end
    lat = n;
    @(posedge clk); #1;
  endtask

  task automatic rand_ops(input int i, input int cnt);
    logic [31:0] d;
    logic e;
    int l, w, r;
    logic [3:0] c;
    for (int n = 0; n < cnt; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      r = int'($urandom_range(0, 9));
      if (r == 0) c = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF;
      else c = 4'((r % 5) + 1);
      do_req(i, c, $urandom(), $urandom(), d, e, l, w);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic e;
    int l, w;
    req_vld = '0; req_cmd = '0; req_din1 = '0; req_din2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADD, FPU latency 3
    fpu_lat = 3;
    do_req(0, ADD, F1, F2, d, e, l, w);
    chk("add_data", d, F3);
    chk("add_err", 32'(e), 0);
    chk("add_ack_wait", 32'(w), 0);
    chk("add_lat", 32'(l), 5);

    // invalid command from requester 2
    do_req(2, 4'hF, F1, F2, d, e, l, w);
    chk("inv_data", d, 0);
    chk("inv_err", 32'(e), 1);
    chk("inv_lat", 32'(l), 1);

    // requesters 0 and 1 continuously valid: grants alternate starting at 0
    fork
      begin
        logic [31:0] d0; logic e0; int l0, w0;
        for (int k = 0; k < 3; k++) begin
          do_req(0, MUL, F2, F3, d0, e0, l0, w0);
          chk("mul_data", d0, 32'h40C00000);
          chk("mul_wait", 32'(w0), (k == 0) ? 32'd0 : 32'd6);
        end
      end
      begin
        logic [31:0] d1; logic e1; int l1, w1;
        for (int k = 0; k < 3; k++) begin
          do_req(1, DIV, F1, F4, d1, e1, l1, w1);
          chk("div_data", d1, 32'h3E800000);
          chk("div_wait", 32'(w1), 6);
        end
      end
    join

    // 20-cycle FPU, second request blocked until RESP
    fpu_lat = 20;
    fork
      begin
        logic [31:0] d0; logic e0; int l0, w0;
        do_req(0, ADD, F1, F2, d0, e0, l0, w0);
        chk("slow_lat", 32'(l0), 22);
        chk("slow_data", d0, F3);
      end
      begin
        logic [31:0] d1; logic e1; int l1, w1;
        repeat (3) @(posedge clk);
        #1;
        do_req(1, MUL, F2, F3, d1, e1, l1, w1);
        chk("blocked_wait", 32'(w1), 20);
        chk("blocked_data", d1, 32'h40C00000);
      end
    join

    // reset during WAIT: operation lost, requester 0 regains priority
    req_cmd[3:0] = ADD; req_din1[31:0] = F1; req_din2[31:0] = F2; req_vld[0] = 1'b1;
    @(negedge clk);
    chk("rst_case_ack", 32'(req_ack), 32'b001);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_fpu_cmd", 32'(fpu_cmd), 0);
    chk("async_fpu_din1", fpu_din1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) begin @(posedge clk); #1; end
    fpu_lat = 3;
    fork
      begin
        logic [31:0] d0; logic e0; int l0, w0;
        do_req(0, ADD, F1, F2, d0, e0, l0, w0);
        chk("post_rst_w0", 32'(w0), 0);
      end
      begin
        logic [31:0] d1; logic e1; int l1, w1;
        do_req(1, DIV, F1, F4, d1, e1, l1, w1);
        chk("post_rst_w1", 32'(w1), 6);
      end
    join

`ifdef FPU_ARB_TIMEOUT_EN
    fpu_never = 1'b1;
    do_req(0, ADD, F1, F2, d, e, l, w);
    chk("to_err", 32'(e), 1);
    chk("to_data", d, 0);
    chk("to_lat", 32'(l), TO + 2);
    fpu_never = 1'b0;
    fpu_lat = TO;
    do_req(0, ADD, F1, F2, d, e, l, w);
    chk("to_edge_err", 32'(e), 0);
    chk("to_edge_data", d, F3);
    chk("to_edge_lat", 32'(l), TO + 2);
`endif

    // randomized traffic from all requesters
    fpu_rand = 1'b1;
    fork
      rand_ops(0, 12);
      rand_ops(1, 12);
      rand_ops(2, 12);
    join
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
